led_pattern_gen: RTL and testbench

//  Multi-channel LED pattern generator; successor to the single fixed-rate board blinker.
//  Per channel, selects OFF / ON / BLINK (programmable period in ms) / DIM (8-bit PWM).

---
 rtl/led_pkg.sv | 41 ++++
 rtl/ms_tick_gen.sv | 52 +++++
 rtl/led_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED pattern generator and its helpers.
//   Holds the channel mode encodings, the field widths used on the config
//   port, and a small helper that turns one channel's stored state into
//   its "lit" value, so the top level stays a plain generate loop.
// ---------------------------------------------------------------------------
package led_pkg;

    // Width of the per-channel mode field and the DIM duty field.
    localparam int MODE_W = 2;
    localparam int DUTY_W = 8;

    // Mode encodings as they appear on cfg_mode.
    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_DIM   = 2'd3;

    // Decide whether a channel's LED should be active this cycle.
    // DIM compares the shared PWM counter against the duty, so a duty of 0
    // never lights and a duty of 255 lights on 255 of every 256 clocks.
    function automatic logic led_lit(
        input logic [MODE_W-1:0] mode,
        input logic              blink_state,
        input logic [DUTY_W-1:0] pwm_cnt,
        input logic [DUTY_W-1:0] duty
    );
        logic lit;
        lit = 1'b0;
        case (mode)
            MODE_OFF:   lit = 1'b0;
            MODE_ON:    lit = 1'b1;
            MODE_BLINK: lit = blink_state;
            MODE_DIM:   lit = (pwm_cnt < duty);
            default:    lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
//   Divides the board clock down to a one-cycle pulse every millisecond.
//   Kept separate so other board designs can reuse the same 1 ms timebase.
//
//   Ports:
//     clk_i   in   1   board clock, all logic on posedge
//     rst_ni  in   1   synchronous active-low reset
//     tick_o  out  1   registered one-cycle pulse every CLK_FREQ_HZ/1000 clocks
//
//   The divisor must be an integer of at least 2.
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int CLK_FREQ_HZ = 27_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int DIV   = CLK_FREQ_HZ / 1000;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap;

    // The prescaler counts 0..DIV-1. The tick is raised on the cycle after
    // the counter reaches its last value, so the pulse comes out of a flop
    // and the first one appears exactly DIV clocks after reset release.
    always_comb begin
        wrap   = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        tick_d = wrap;
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//   Multi-channel LED pattern generator. Each channel is independently set
//   to OFF, ON, BLINK (programmable half-period in ms) or DIM (8-bit PWM).
//   Configuration arrives on a one-cycle write port with no backpressure.
//   A shared 1 ms tick drives every blinking channel and is also exported.
//
//   Ports:
//     clk            in   1                   board clock, all logic on posedge
//     rst_n          in   1                   synchronous active-low reset
//     cfg_valid      in   1                   config write strobe, one cycle per write
//     cfg_ch         in   $clog2(CHANNELS)+1  target channel index
//     cfg_mode       in   2                   0 OFF, 1 ON, 2 BLINK, 3 DIM
//     cfg_period_ms  in   PERIOD_W            BLINK half-period in ms (0 acts as 1)
//     cfg_duty       in   8                   DIM duty in 1/256 steps
//     cfg_err        out  1                   one-cycle pulse: out-of-range write rejected
//     tick_ms        out  1                   one-cycle pulse every millisecond
//     led            out  CHANNELS            LED pins with polarity applied
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int                CLK_FREQ_HZ    = 27_000_000,
    parameter int                CHANNELS       = 6,
    parameter int                PERIOD_W       = 16,
    parameter int                DEFAULT_PERIOD = 500,
    parameter logic [MODE_W-1:0] RESET_MODE     = MODE_BLINK,
    parameter bit                ACTIVE_LOW     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    input  logic [$clog2(CHANNELS):0]     cfg_ch,
    input  logic [MODE_W-1:0]             cfg_mode,
    input  logic [PERIOD_W-1:0]           cfg_period_ms,
    input  logic [DUTY_W-1:0]             cfg_duty,
    output logic                          cfg_err,
    output logic                          tick_ms,
    output logic [CHANNELS-1:0]           led
);

    localparam int CH_W = $clog2(CHANNELS) + 1;

    // Pin level that keeps an LED dark, replicated across all channels.
    localparam logic [CHANNELS-1:0] DARK = {CHANNELS{ACTIVE_LOW}};

    logic [DUTY_W-1:0]   pwm_q;
    logic [DUTY_W-1:0]   pwm_d;
    logic                err_q;
    logic                err_d;
    logic [CHANNELS-1:0] led_q;
    logic [CHANNELS-1:0] led_d;
    logic [CHANNELS-1:0] lit;
    logic                cfg_ch_ok;

    // Shared millisecond timebase.
    ms_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rst_n),
        .tick_o(tick_ms)
    );

    // A write to a channel index that does not exist changes nothing, but
    // the caller gets a one-cycle error pulse so a UART decoder or similar
    // can report the bad command.
    always_comb begin
        cfg_ch_ok = (cfg_ch < CH_W'(CHANNELS));
        err_d     = cfg_valid && !cfg_ch_ok;
    end

    // The PWM counter is shared by every DIM channel and simply wraps, which
    // gives a 256-clock PWM frame. The LED pins are registered so the pins
    // see a clean flop output one clock after the internal state.
    always_comb begin
        pwm_d = pwm_q + DUTY_W'(1);
        led_d = lit ^ DARK;
    end

    // Shared registers: PWM counter, error pulse and LED pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= '0;
            err_q <= 1'b0;
            led_q <= DARK;
        end else begin
            pwm_q <= pwm_d;
            err_q <= err_d;
            led_q <= led_d;
        end
    end

    // One block of state per channel. Each channel only reacts to writes
    // addressed to its own index, so writes to other channels leave its
    // blink timing untouched.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [MODE_W-1:0]   mode_q;
        logic [MODE_W-1:0]   mode_d;
        logic [PERIOD_W-1:0] period_q;
        logic [PERIOD_W-1:0] period_d;
        logic [DUTY_W-1:0]   duty_q;
        logic [DUTY_W-1:0]   duty_d;
        logic [PERIOD_W-1:0] ms_cnt_q;
        logic [PERIOD_W-1:0] ms_cnt_d;
        logic                blink_q;
        logic                blink_d;
        logic [PERIOD_W-1:0] eff_period;
        logic                wr_hit;

        assign wr_hit     = cfg_valid && (cfg_ch == CH_W'(i));
        assign eff_period = (period_q == '0) ? PERIOD_W'(1) : period_q;

        // A write always wins over a coincident tick: the channel restarts
        // its pattern from a fresh, lit half-period. Counting uses >= so that
        // a count left over from a longer period cannot run past the end and
        // wrap all the way around. Outside BLINK the counter simply holds.
        always_comb begin
            mode_d   = mode_q;
            period_d = period_q;
            duty_d   = duty_q;
            ms_cnt_d = ms_cnt_q;
            blink_d  = blink_q;
            if (wr_hit) begin
                mode_d   = cfg_mode;
                period_d = cfg_period_ms;
                duty_d   = cfg_duty;
                ms_cnt_d = '0;
                blink_d  = 1'b1;
            end else if (tick_ms && (mode_q == MODE_BLINK)) begin
                if (ms_cnt_q >= eff_period - PERIOD_W'(1)) begin
                    ms_cnt_d = '0;
                    blink_d  = !blink_q;
                end else begin
                    ms_cnt_d = ms_cnt_q + PERIOD_W'(1);
                end
            end
        end

        // Channel configuration and blink timing registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mode_q   <= RESET_MODE;
                period_q <= PERIOD_W'(DEFAULT_PERIOD);
                duty_q   <= '0;
                ms_cnt_q <= '0;
                blink_q  <= 1'b1;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                duty_q   <= duty_d;
                ms_cnt_q <= ms_cnt_d;
                blink_q  <= blink_d;
            end
        end

        assign lit[i] = led_lit(mode_q, blink_q, pwm_q, duty_q);
    end

    assign cfg_err = err_q;
    assign led     = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//   Self-checking bench for led_pattern_gen with a 10 kHz clock (10 clocks
//   per millisecond tick), four channels, active-low pins and a default
//   half-period of 3 ms. A behavioural model predicts led, tick_ms and
//   cfg_err on every clock; directed literal checks pin the model down.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period_ms;
    logic [7:0]  cfg_duty;
    logic        cfg_err;
    logic        tick_ms;
    logic [3:0]  led;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state: configuration plus the number of ticks a blinking
    // channel has seen since it was (re)started. The blink phase follows
    // directly from that count and the effective half-period.
    int   mMode[NCH];
    int   mPeriod[NCH];
    int   mDuty[NCH];
    int   mTicks[NCH];
    int   edgeNum = 0;
    bit   expTick = 1'b0;
    bit   expErr  = 1'b0;
    logic [3:0] expLed = 4'hF;
    bit   modelValid = 1'b0;

    led_pattern_gen #(
        .CLK_FREQ_HZ   (10_000),
        .CHANNELS      (NCH),
        .PERIOD_W      (16),
        .DEFAULT_PERIOD(3),
        .RESET_MODE    (2'd2),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_period_ms(cfg_period_ms),
        .cfg_duty     (cfg_duty),
        .cfg_err      (cfg_err),
        .tick_ms      (tick_ms),
        .led          (led)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Whether channel i should be lit given the model state before an edge.
    function automatic bit litOf(input int i, input int pwm);
        int eff;
        eff = (mPeriod[i] == 0) ? 1 : mPeriod[i];
        case (mMode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((mTicks[i] / eff) % 2) == 0;
            default: return pwm < mDuty[i];
        endcase
    endfunction

    // Behavioural model, advanced on every rising edge using the inputs
    // the DUT sees on that edge. The PWM value is the number of clocks
    // since reset release modulo 256; ticks come every 10 clocks.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mMode[i]   = 2;
                mPeriod[i] = 3;
                mDuty[i]   = 0;
                mTicks[i]  = 0;
            end
            edgeNum = 0;
            expTick = 1'b0;
            expErr  = 1'b0;
            expLed  = 4'hF;
        end else begin
            for (int i = 0; i < NCH; i++)
                expLed[i] = !litOf(i, edgeNum % 256);
            for (int i = 0; i < NCH; i++) begin
                if (cfg_valid && int'(cfg_ch) == i) begin
                    mMode[i]   = int'(cfg_mode);
                    mPeriod[i] = int'(cfg_period_ms);
                    mDuty[i]   = int'(cfg_duty);
                    mTicks[i]  = 0;
                end else if (expTick && mMode[i] == 2) begin
                    mTicks[i]++;
                end
            end
            expErr  = cfg_valid && (int'(cfg_ch) >= NCH);
            edgeNum++;
            expTick = (edgeNum % 10) == 0;
        end
        modelValid = 1'b1;
    end

    // Compare DUT outputs against the model midway between rising edges.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("led", 32'(led), 32'(expLed));
            checkOutput("tick_ms", 32'(tick_ms), 32'(expTick));
            checkOutput("cfg_err", 32'(cfg_err), 32'(expErr));
        end
    end

    // Issue one config write; called at a falling edge, returns at the
    // falling edge after the write has been sampled.
    task automatic applyStimulus(input int ch, input int mode, input int period, input int duty);
        cfg_valid     = 1'b1;
        cfg_ch        = 3'(ch);
        cfg_mode      = 2'(mode);
        cfg_period_ms = 16'(period);
        cfg_duty      = 8'(duty);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_ch        = '0;
        cfg_mode      = '0;
        cfg_period_ms = '0;
        cfg_duty      = '0;

        // Reset held for 30 clocks, then released.
        repeat (30) @(negedge clk);
        checkOutput("led_in_reset", 32'(led), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("led_first_lit", 32'(led), 32'h0);
        repeat (8) @(negedge clk);
        checkOutput("tick_clk9", 32'(tick_ms), 32'h0);
        @(negedge clk);
        checkOutput("tick_clk10", 32'(tick_ms), 32'h1);
        repeat (21) @(negedge clk);
        checkOutput("led_clk31_lit", 32'(led), 32'h0);
        @(negedge clk);
        checkOutput("led_clk32_dark", 32'(led), 32'hF);

        // Channel 1 blinks with period 0, i.e. toggles on every tick.
        applyStimulus(1, 2, 0, 0);
        repeat (60) @(negedge clk);

        // Channel 2 DIM: duty 64, 0 and 255 over a full PWM frame.
        applyStimulus(2, 3, 0, 64);
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (!led[2]) cnt++;
        end
        checkOutput("dim64_low_clks", 32'(cnt), 32'd64);

        applyStimulus(2, 3, 0, 0);
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (!led[2]) cnt++;
        end
        checkOutput("dim0_low_clks", 32'(cnt), 32'd0);

        applyStimulus(2, 3, 0, 255);
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (led[2]) cnt++;
        end
        checkOutput("dim255_high_clks", 32'(cnt), 32'd1);

        // Channel 0 OFF then ON, then out-of-range writes.
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ch0_off", 32'(led[0]), 32'h1);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("ch0_on", 32'(led[0]), 32'h0);

        cfg_valid = 1'b1;
        cfg_ch    = 3'd5;
        cfg_mode  = 2'd0;
        cnt = 0;
        @(negedge clk);
        if (cfg_err) cnt++;
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cfg_err) cnt++;
        end
        checkOutput("err_pulse_count", 32'(cnt), 32'd1);
        checkOutput("ch0_still_on", 32'(led[0]), 32'h0);
        applyStimulus(4, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Write on channel 3 coincident with a tick.
        for (int k = 0; k < 12 && (edgeNum % 10) != 0; k++) @(negedge clk);
        checkOutput("tick_aligned", 32'(tick_ms), 32'h1);
        applyStimulus(3, 2, 2, 0);
        @(negedge clk);
        checkOutput("ch3_restart_lit", 32'(led[3]), 32'h0);
        repeat (60) @(negedge clk);

        // Reset coincident with a write: reset values must win.
        rst_n     = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_mode  = 2'd0;
        @(negedge clk);
        checkOutput("rst_wr_led", 32'(led), 32'hF);
        checkOutput("rst_wr_err", 32'(cfg_err), 32'h0);
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checkOutput("rst_wr_ch0_blink", 32'(led), 32'h0);
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
